// File: rtl/scanout_pkg.sv
// rtl/scanout_pkg.sv - shared types and constants for the frame scan-out block
//
// Purpose: FSM state encoding and the SRAM read-to-pixel latency used by
//          frame_scanout and its helpers.
package scanout_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_STOPPING
    } scan_state_e;

    // Cycles from read_addrs to the registered pixel_out/pixel_valid.
    localparam int SCANOUT_RD_LAT = 2;

endpackage

// File: rtl/frame_scanout_if.sv
// rtl/frame_scanout_if.sv - SRAM, pixel and swap handshake bundle for frame_scanout
//
// Purpose: groups the SRAM read port, the pixel stream and the renderer swap
//          handshake of frame_scanout.
// Signals:
//   swap_req    renderer -> scanout, one-cycle pulse: back buffer complete
//   swap_ack    scanout -> renderer, one-cycle pulse: swap performed
//   flip        scanout -> SRAM, one-cycle buffer flip pulse
//   read_addrs  scanout -> SRAM, per-channel read address (all identical)
//   data_outs   SRAM -> scanout, per-channel read data, one cycle after address
//   pixel_out   scanout -> display, channel 0 in LSBs
//   pixel_valid scanout -> display, pixel_out is an active pixel
//   hsync       scanout -> display, high during horizontal blank
//   vsync       scanout -> display, high during vertical blank lines
// Modports: master = scan-out side, slave = SRAM/renderer/display side.
interface frame_scanout_if #(
    parameter int CHANNELS  = 1,
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 1
) ();

    logic                                     swap_req;
    logic                                     swap_ack;
    logic                                     flip;
    logic [CHANNELS-1:0][ADDR_SIZE-1:0]       read_addrs;
    logic [CHANNELS-1:0][DATA_SIZE-1:0]       data_outs;
    logic [DATA_SIZE*CHANNELS-1:0]            pixel_out;
    logic                                     pixel_valid;
    logic                                     hsync;
    logic                                     vsync;

    modport master (
        input  swap_req,
        input  data_outs,
        output swap_ack,
        output flip,
        output read_addrs,
        output pixel_out,
        output pixel_valid,
        output hsync,
        output vsync
    );

    modport slave (
        output swap_req,
        output data_outs,
        input  swap_ack,
        input  flip,
        input  read_addrs,
        input  pixel_out,
        input  pixel_valid,
        input  hsync,
        input  vsync
    );

endinterface

// File: rtl/scanout_timing_gen.sv
// rtl/scanout_timing_gen.sv - raster h/v counters and blanking flags
//
// Purpose: horizontal/vertical raster counters for the scan-out stage.
// Ports:
//   clk, rst     clock, synchronous active-high reset (counters to 0)
//   run          advance the raster by one pixel this cycle
//   active       current position is a visible pixel
//   h_blank      current position is in horizontal blank
//   v_blank      current position is on a vertical blank line
//   frame_last   current position is the last cycle of the frame
//   next_active  the position after this one (if advanced) is visible
//   parity       (h ^ v) & 1 of the current position
module scanout_timing_gen #(
    parameter int H_ACTIVE = 16,
    parameter int V_ACTIVE = 16,
    parameter int H_BLANK  = 4,
    parameter int V_BLANK  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic active,
    output logic h_blank,
    output logic v_blank,
    output logic frame_last,
    output logic next_active,
    output logic parity
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    logic [HW-1:0] h_cnt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_nxt;
    logic          h_wrap;
    logic          v_wrap;

    always_comb begin
        h_wrap = (h_cnt == HW'(H_TOTAL - 1));
        v_wrap = (v_cnt == VW'(V_TOTAL - 1));
        h_nxt  = h_wrap ? '0 : h_cnt + 1'b1;
        v_nxt  = h_wrap ? (v_wrap ? '0 : v_cnt + 1'b1) : v_cnt;
    end

    // Counters sit at 0 while not running; a frame always ends on a wrap,
    // so stopping leaves them at the frame origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run) begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    assign h_blank     = (h_cnt >= HW'(H_ACTIVE));
    assign v_blank     = (v_cnt >= VW'(V_ACTIVE));
    assign active      = !h_blank && !v_blank;
    assign frame_last  = h_wrap && v_wrap;
    assign next_active = (h_nxt < HW'(H_ACTIVE)) && (v_nxt < VW'(V_ACTIVE));
    assign parity      = h_cnt[0] ^ v_cnt[0];

endmodule

// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - raster scan-out of the SRAM front buffer with buffer flip
//
// Purpose: raster-scans the front buffer, drives the SRAM read address,
//          realigns the returned data into a pixel stream with hsync/vsync
//          and issues the buffer flip at frame end when a swap is pending.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset; aborts the frame, no flip
//   enable     run scan-out; deassertion takes effect at frame end
//   test_mode  (only with SCANOUT_TEST_PATTERN_EN) checkerboard instead of SRAM data
//   bus        frame_scanout_if master: SRAM port, pixel stream, swap handshake
// Configuration macro: SCANOUT_TEST_PATTERN_EN adds the test_mode input.
module frame_scanout
    import scanout_pkg::*;
#(
    parameter int CHANNELS  = 1,
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 1,
    parameter int H_ACTIVE  = 16,
    parameter int V_ACTIVE  = 16,
    parameter int H_BLANK   = 4,
    parameter int V_BLANK   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
`ifdef SCANOUT_TEST_PATTERN_EN
    input  logic test_mode,
`endif
    frame_scanout_if.master bus
);

    localparam int PW  = DATA_SIZE * CHANNELS;
    localparam int LAT = SCANOUT_RD_LAT;
    localparam int PL  = LAT - 1;

`ifndef SCANOUT_TEST_PATTERN_EN
    // Without the pattern port the pattern select is tied off.
    logic test_mode;
    assign test_mode = 1'b0;
`endif

    scan_state_e          state;
    logic                 running;
    logic                 active;
    logic                 h_blank;
    logic                 v_blank;
    logic                 frame_last;
    logic                 next_active;
    logic                 parity;
    logic                 pending;
    logic                 flip_now;
    logic [ADDR_SIZE-1:0] addr;
    logic [LAT-1:0]       act_sr;
    logic [LAT-1:0]       hs_sr;
    logic [LAT-1:0]       vs_sr;
    logic [PL-1:0]        par_sr;
    logic [PW-1:0]        pix_r;

    assign running = (state != S_IDLE);

    scanout_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_BLANK  (V_BLANK)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .run         (running),
        .active      (active),
        .h_blank     (h_blank),
        .v_blank     (v_blank),
        .frame_last  (frame_last),
        .next_active (next_active),
        .parity      (parity)
    );

    // A request arriving in the last cycle itself is honoured in that cycle,
    // so the flip decode looks at swap_req directly as well as the flag.
    assign flip_now     = running && frame_last && (pending || bus.swap_req);
    assign bus.flip     = flip_now;
    assign bus.swap_ack = flip_now;

    // SCAN and STOPPING scan identically; enable is only acted on at frame
    // end, where it decides between another frame and IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) state <= S_SCAN;
                end
                S_SCAN, S_STOPPING: begin
                    if (frame_last) state <= enable ? S_SCAN : S_IDLE;
                    else            state <= enable ? S_SCAN : S_STOPPING;
                end
                default: state <= S_IDLE;
            endcase
            pending <= flip_now ? 1'b0 : (pending || bus.swap_req);
        end
    end

    // Running linear address: steps only into visible pixels, so it holds the
    // last visible address through blanking and lands on v*H_ACTIVE+h
    // without a multiplier.
    always_ff @(posedge clk) begin
        if (rst || !running || frame_last) begin
            addr <= '0;
        end else if (next_active) begin
            addr <= addr + 1'b1;
        end
    end

    assign bus.read_addrs = {CHANNELS{addr}};

    // Sideband delay lines; the oldest stage is the registered output.
    // The pixel register samples SRAM data one stage earlier, where it
    // lines up with its own address.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_sr <= '0;
            hs_sr  <= '0;
            vs_sr  <= '0;
            par_sr <= '0;
            pix_r  <= '0;
        end else begin
            act_sr <= {act_sr[LAT-2:0], running && active};
            hs_sr  <= {hs_sr[LAT-2:0],  running && h_blank};
            vs_sr  <= {vs_sr[LAT-2:0],  running && v_blank};
            par_sr <= PL'({par_sr, parity});
            if (!act_sr[LAT-2])  pix_r <= '0;
            else if (test_mode)  pix_r <= {PW{par_sr[PL-1]}};
            else                 pix_r <= bus.data_outs;
        end
    end

    assign bus.pixel_out   = pix_r;
    assign bus.pixel_valid = act_sr[LAT-1];
    assign bus.hsync       = hs_sr[LAT-1];
    assign bus.vsync       = vs_sr[LAT-1];

endmodule

// File: tb/tb_frame_scanout.sv
// tb/tb_frame_scanout.sv - randomized scan-out bench against a frame-level reference model
module tb_frame_scanout;

    localparam int CH = 2;
    localparam int AS = 8;
    localparam int DS = 4;
    localparam int HA = 4;
    localparam int VA = 2;
    localparam int HB = 2;
    localparam int VB = 1;
    localparam int HT = HA + HB;
    localparam int VT = VA + VB;
    localparam int FT = HT * VT;
    localparam int W  = DS * CH;

    typedef struct packed {
        logic         v;
        logic         hs;
        logic         vs;
        logic [W-1:0] pix;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
`ifdef SCANOUT_TEST_PATTERN_EN
    logic test_mode = 1'b0;
`endif

    frame_scanout_if #(.CHANNELS(CH), .ADDR_SIZE(AS), .DATA_SIZE(DS)) bus ();

    frame_scanout #(
        .CHANNELS  (CH),
        .ADDR_SIZE (AS),
        .DATA_SIZE (DS),
        .H_ACTIVE  (HA),
        .V_ACTIVE  (VA),
        .H_BLANK   (HB),
        .V_BLANK   (VB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
`ifdef SCANOUT_TEST_PATTERN_EN
        .test_mode (test_mode),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Double-buffered SRAM: synchronous read, flip toggles the front buffer.
    logic [DS-1:0] mem [2][CH][2**AS];
    logic          sram_fb = 1'b0;

    always @(posedge clk) begin
        for (int c = 0; c < CH; c++) bus.data_outs[c] <= mem[sram_fb][c][bus.read_addrs[c]];
        if (bus.flip) sram_fb <= ~sram_fb;
    end

    // Reference model state: frame position, run flag, pending swap,
    // expected front buffer and the two pixels in flight.
    bit   m_run  = 1'b0;
    int   m_k    = 0;
    bit   m_pend = 1'b0;
    bit   m_fb   = 1'b0;
    pix_t e1     = '0;
    pix_t e2     = '0;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_flip = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Address on the SRAM bus at frame cycle k: the visible pixel index, or
    // the most recent visible one during blanking.
    function automatic int addr_of(input int k);
        int h;
        int v;
        h = k % HT;
        v = k / HT;
        if (v >= VA) return HA * VA - 1;
        if (h >= HA) return v * HA + HA - 1;
        return v * HA + h;
    endfunction

    // One clock cycle: drive inputs, check this cycle's outputs, advance model.
    task automatic cyc(input bit en, input bit sr, input bit r);
        bit   exp_flip;
        bit   nxt_run;
        int   a;
        int   h;
        int   v;
        pix_t cur;
        enable       = en;
        bus.swap_req = sr;
        rst          = r;
        #1;
        a        = addr_of(m_k);
        exp_flip = m_run && (m_k == FT - 1) && (m_pend || sr);
        for (int c = 0; c < CH; c++) check("read_addrs", bus.read_addrs[c], a);
        check("flip", bus.flip, exp_flip);
        check("swap_ack", bus.swap_ack, exp_flip);
        check("pixel_valid", bus.pixel_valid, e2.v);
        check("pixel_out", bus.pixel_out, e2.pix);
        check("hsync", bus.hsync, e2.hs);
        check("vsync", bus.vsync, e2.vs);
        if (bus.flip === 1'b1) n_flip++;

        h     = m_k % HT;
        v     = m_k / HT;
        cur   = '0;
        cur.v = m_run && (h < HA) && (v < VA);
        cur.hs = m_run && (h >= HA);
        cur.vs = m_run && (v >= VA);
        if (cur.v) for (int c = 0; c < CH; c++) cur.pix[c*DS +: DS] = mem[m_fb][c][a];
        e2 = e1;
        e1 = cur;
        if (exp_flip) m_fb = !m_fb;

        if (r) begin
            m_run  = 1'b0;
            m_k    = 0;
            m_pend = 1'b0;
            e1     = '0;
            e2     = '0;
        end else begin
            nxt_run = m_run ? ((m_k == FT - 1) ? en : 1'b1) : en;
            m_k     = m_run ? (m_k + 1) % FT : 0;
            m_run   = nxt_run;
            m_pend  = exp_flip ? 1'b0 : (m_pend || sr);
        end
        @(negedge clk);
    endtask

    // Run enabled until the model sits at frame cycle k of a running frame.
    task automatic goto_k(input int k);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 4 * FT && !hit; i++) begin
            if (m_run && m_k == k) hit = 1'b1;
            else cyc(1'b1, 1'b0, 1'b0);
        end
        check("goto_k_reached", hit, 1'b1);
    endtask

    initial begin
        int f0;
        for (int a = 0; a < 2**AS; a++)
            for (int c = 0; c < CH; c++) begin
                mem[0][c][a] = DS'(a + c);
                mem[1][c][a] = DS'($urandom);
            end
        bus.swap_req = 1'b0;
        bus.data_outs = '0;
        @(negedge clk);

        // Reset state, then a plain scan of two frames (data = addr).
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (2 * FT + 1) cyc(1'b1, 1'b0, 1'b0);

        // Single swap request mid-frame: exactly one flip at frame end.
        goto_k(5);
        f0 = n_flip;
        cyc(1'b1, 1'b1, 1'b0);
        goto_k(0);
        check("flips_after_one_req", n_flip - f0, 1);
        repeat (FT) cyc(1'b1, 1'b0, 1'b0);

        // Three frames with no request, then two requests in one frame.
        f0 = n_flip;
        repeat (3 * FT) cyc(1'b1, 1'b0, 1'b0);
        check("flips_no_req", n_flip - f0, 0);
        goto_k(2);
        f0 = n_flip;
        cyc(1'b1, 1'b1, 1'b0);
        goto_k(9);
        cyc(1'b1, 1'b1, 1'b0);
        goto_k(0);
        check("flips_coalesced", n_flip - f0, 1);

        // Request in the last frame cycle itself.
        goto_k(FT - 1);
        f0 = n_flip;
        cyc(1'b1, 1'b1, 1'b0);
        check("flip_same_cycle", n_flip - f0, 1);

        // Stop mid-frame: frame completes, then idle; restart from address 0.
        goto_k(3);
        cyc(1'b0, 1'b0, 1'b0);
        repeat (FT + 6) cyc(1'b0, 1'b0, 1'b0);
        check("idle_pixel_valid", bus.pixel_valid, 1'b0);
        check("idle_vsync", bus.vsync, 1'b0);
        check("idle_read_addr", bus.read_addrs[0], 0);
        goto_k(0);
        cyc(1'b1, 1'b0, 1'b0);

        // Reset mid-frame with a swap pending: no flip afterwards.
        goto_k(5);
        cyc(1'b1, 1'b1, 1'b0);
        goto_k(9);
        cyc(1'b1, 1'b0, 1'b1);
        check("post_reset_valid", bus.pixel_valid, 1'b0);
        f0 = n_flip;
        repeat (2 * FT + 2) cyc(1'b1, 1'b0, 1'b0);
        check("flips_after_reset", n_flip - f0, 0);

        // Randomized enable / swap / reset traffic.
        for (int i = 0; i < 800; i++)
            cyc(($urandom % 8) != 0, ($urandom % 10) == 0, ($urandom % 150) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
